// File: rtl/axil_intr_responder.sv
// rtl/axil_intr_responder.sv - AXI4-Lite interrupt register bank (GIE/IER/ISR/IAR/IPR) driving irq
module axil_intr_responder #(
    parameter int          C_S_AXI_DATA_WIDTH  = 32,
    parameter int          C_S_AXI_ADDR_WIDTH  = 5,
    parameter int          C_NUM_OF_INTR       = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFFFFFF,
    parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFFFFFF,
    parameter int          C_IRQ_SENSITIVITY   = 1,
    parameter int          C_IRQ_ACTIVE_LEVEL  = 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic [C_NUM_OF_INTR-1:0]      intr_src,
    output logic                          irq
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int N  = C_NUM_OF_INTR;
    localparam logic [N-1:0] SENS = C_INTR_SENSITIVITY[N-1:0];
    localparam logic [N-1:0] POL  = C_INTR_ACTIVE_STATE[N-1:0];
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
    logic [1:0]    b_resp_q, r_resp_q;
    logic [31:0]   r_data_q;
    logic          gie;
    logic [N-1:0]  ier, isr, act_d;
    logic          irq_int, irq_int_d;

    logic          wr_fire, rd_fire, wr_mapped, rd_mapped;
    logic [31:0]   wr_word, rd_word, wmask, wdata_m, rd_val;
    logic [N-1:0]  act, set_vec, clr_vec;
    logic          irq_act;
    logic          unused_ok;

    assign wr_fire   = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire   = ar_ready_q & S_AXI_ARVALID;
    assign wr_word   = 32'(S_AXI_AWADDR[AW-1:2]);
    assign rd_word   = 32'(S_AXI_ARADDR[AW-1:2]);
    assign wr_mapped = wr_word < 32'd5;
    assign rd_mapped = rd_word < 32'd5;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
    end
    assign wdata_m = 32'(S_AXI_WDATA) & wmask;

    // Sources are normalised so that 1 always means "active"; history holds the normalised value.
    assign act     = ~(intr_src ^ POL);
    assign set_vec = (SENS & act & ~act_d) | (~SENS & act);
    assign clr_vec = (wr_fire && wr_word == 32'd3) ? wdata_m[N-1:0] : '0;

    always_comb begin
        rd_val = '0;
        case (rd_word)
            32'd0:   rd_val[0] = gie;
            32'd1:   rd_val    = 32'(ier);
            32'd2:   rd_val    = 32'(isr);
            32'd4:   rd_val    = 32'(isr & ier);
            default: rd_val    = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
            gie        <= 1'b0;
            ier        <= '0;
            isr        <= '0;
            act_d      <= '0;
            irq_int    <= 1'b0;
            irq_int_d  <= 1'b0;
        end else begin
            aw_ready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~b_valid_q & ~aw_ready_q;
            if (wr_fire) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                if (wr_word == 32'd0) gie <= (gie & ~wmask[0]) | wdata_m[0];
                if (wr_word == 32'd1) ier <= (ier & ~wmask[N-1:0]) | wdata_m[N-1:0];
            end else if (S_AXI_BREADY) begin
                b_valid_q <= 1'b0;
            end

            ar_ready_q <= S_AXI_ARVALID & ~r_valid_q & ~ar_ready_q;
            if (rd_fire) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_val;
                r_resp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RREADY) begin
                r_valid_q <= 1'b0;
            end

            // Set is applied after clear so a coincident source event wins.
            isr       <= (isr & ~clr_vec) | set_vec;
            act_d     <= act;
            irq_int   <= gie & |(isr & ier);
            irq_int_d <= irq_int;
        end
    end

    assign irq_act = (C_IRQ_SENSITIVITY != 0) ? irq_int : (irq_int & ~irq_int_d);
    assign irq     = (C_IRQ_ACTIVE_LEVEL != 0) ? irq_act : ~irq_act;

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = b_resp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RRESP   = r_resp_q;
    assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(r_data_q);

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         wdata_m, wr_word, rd_word};

endmodule
